// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared FSM encodings and index-width helpers for the AXIS round-robin arbiter
package axis_arb_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int IDX_W(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: one-deep registered AXIS stage; tid path exists only when AXIS_ARB_TID_EN is defined
module axis_reg_slice #(
  parameter int DW = 32
`ifdef AXIS_ARB_TID_EN
  , parameter int IW = 2
`endif
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tlast,
`ifdef AXIS_ARB_TID_EN
  input  logic [IW-1:0] s_tid,
  output logic [IW-1:0] m_tid,
`endif
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tlast
);
  assign s_tready = !m_tvalid || m_tready;
  // Load a new beat when the slot is free or draining, otherwise empty it once taken
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else if (s_tvalid && s_tready) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
      m_tlast  <= s_tlast;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
`ifdef AXIS_ARB_TID_EN
  // Source index travels with its beat
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) m_tid <= '0;
    else if (s_tvalid && s_tready) m_tid <= s_tid;
`endif
endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-atomic round-robin AXIS arbiter; AXIS_ARB_TID_EN adds the m_axis_tid output
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int TDATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]             s_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [TDATA_WIDTH-1:0]         m_axis_tdata,
  output logic                           m_axis_tlast
`ifdef AXIS_ARB_TID_EN
  , output logic [IDX_W(NUM_SRC)-1:0]    m_axis_tid
`endif
);
  localparam int IW = IDX_W(NUM_SRC);
  logic [0:0]             state;
  logic [IW-1:0]          rr_ptr, grant, pick, rr_next;
  logic [NUM_SRC-1:0]     rot;
  logic                   found, busy, slice_ready, sel_valid, sel_last, accept;
  logic [TDATA_WIDTH-1:0] sel_data;
  assign busy          = state == ST_BUSY;
  assign rot           = NUM_SRC'({s_axis_tvalid, s_axis_tvalid} >> rr_ptr);
  assign rr_next       = (grant == IW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
  assign accept        = busy && sel_valid && slice_ready;
  assign s_axis_tready = (busy && slice_ready) ? (NUM_SRC'(1) << grant) : '0;
  // First requesting source at or after rr_ptr in circular order
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_ptr) + k) % NUM_SRC);
      end
  end
  // Route the granted source's beat towards the output slice
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (grant == IW'(k)) begin
        sel_valid = s_axis_tvalid[k];
        sel_last  = s_axis_tlast[k];
        sel_data  = s_axis_tdata[k*TDATA_WIDTH +: TDATA_WIDTH];
      end
  end
  // Grant held from arbitration until the packet's tlast beat is accepted
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else if (!busy) begin
      if (found) begin
        grant <= pick;
        state <= ST_BUSY;
      end
    end else if (accept && sel_last) begin
      state  <= ST_IDLE;
      rr_ptr <= rr_next;
    end
  axis_reg_slice #(
    .DW(TDATA_WIDTH)
`ifdef AXIS_ARB_TID_EN
    , .IW(IW)
`endif
  ) u_slice (
    .clk      (clk),
    .rstn     (rstn),
    .s_tvalid (busy && sel_valid),
    .s_tready (slice_ready),
    .s_tdata  (sel_data),
    .s_tlast  (sel_last),
`ifdef AXIS_ARB_TID_EN
    .s_tid    (grant),
    .m_tid    (m_axis_tid),
`endif
    .m_tvalid (m_axis_tvalid),
    .m_tready (m_axis_tready),
    .m_tdata  (m_axis_tdata),
    .m_tlast  (m_axis_tlast)
  );
endmodule
